// File: rtl/time_pkg.sv
// rtl/time_pkg.sv - shared field widths, time bus packing and set-mode FSM states
package time_pkg;

  localparam int HH_W       = 5;
  localparam int MM_W       = 6;
  localparam int SS_W       = 6;
  localparam int TIME_BUS_W = 24;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_ARMED,
    ST_HOLD,
    ST_REPEAT
  } state_e;

  typedef struct packed {
    logic [HH_W-1:0] hh;
    logic [MM_W-1:0] mm;
    logic [SS_W-1:0] ss;
  } time_t;

  // Bus layout: {3'b0, hh, 2'b0, mm, 2'b0, ss}
  function automatic logic [TIME_BUS_W-1:0] pack_time(input time_t t);
    return {3'b0, t.hh, 2'b0, t.mm, 2'b0, t.ss};
  endfunction

  function automatic time_t unpack_time(input logic [TIME_BUS_W-1:0] bus);
    time_t t;
    t.hh = bus[20:16];
    t.mm = bus[13:8];
    t.ss = bus[5:0];
    return t;
  endfunction

endpackage

// File: rtl/mod_step.sv
// rtl/mod_step.sv - combinational modulo increment/decrement of one time field
module mod_step #(
  parameter int WIDTH = 6,
  parameter int MOD   = 60
) (
  input  logic [WIDTH-1:0] val,
  input  logic             up,
  input  logic             dn,
  output logic [WIDTH-1:0] next
);

  always_comb begin
    next = val;
    if (up) begin
      next = (val == WIDTH'(MOD - 1)) ? '0 : val + WIDTH'(1);
    end else if (dn) begin
      next = (val == '0) ? WIDTH'(MOD - 1) : val - WIDTH'(1);
    end
  end

endmodule

// File: rtl/time_set_ctrl.sv
// rtl/time_set_ctrl.sv - set-mode controller: load on entry, step/auto-repeat fields from buttons
module time_set_ctrl
  import time_pkg::*;
#(
  parameter int HOUR_MOD      = 24,
  parameter int REPEAT_DELAY  = 50_000_000,
  parameter int REPEAT_PERIOD = 10_000_000,
  parameter int SEC_EN        = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  set_en,
  input  logic [5:0]            button,
  input  logic [TIME_BUS_W-1:0] time_in,
  output logic [TIME_BUS_W-1:0] time_out,
  output logic                  set_done,
  output logic                  editing
);

  localparam int CNT_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int CNT_W   = $clog2(CNT_MAX);
  localparam logic [5:0] BTN_MASK = (SEC_EN != 0) ? 6'b111111 : 6'b111100;

  state_e           state_q, state_d;
  logic             set_en_q;
  logic [5:0]       btn_q, btn_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             done_q, done_d;
  logic [HH_W-1:0]  hh_q, hh_d, hh_step, hh_load;
  logic [MM_W-1:0]  mm_q, mm_d, mm_step, mm_load;
  logic [SS_W-1:0]  ss_q, ss_d, ss_step, ss_load;
  logic [5:0]       btn_m;
  logic             btn_valid;
  logic             step;
  logic             load;
  time_t            tin;
  time_t            tcur;

  assign btn_m     = button & BTN_MASK;
  assign btn_valid = $onehot(btn_m);

  always_comb begin
    state_d = state_q;
    btn_d   = btn_q;
    cnt_d   = cnt_q;
    done_d  = 1'b0;
    step    = 1'b0;
    load    = 1'b0;
    // Leaving set mode wins over any pending step or repeat.
    if (state_q != ST_IDLE && !set_en) begin
      state_d = ST_IDLE;
      done_d  = 1'b1;
      cnt_d   = '0;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (set_en && !set_en_q) state_d = ST_LOAD;
        end
        ST_LOAD: begin
          load    = 1'b1;
          state_d = ST_ARMED;
        end
        ST_ARMED: begin
          if (btn_valid) begin
            step    = 1'b1;
            btn_d   = btn_m;
            cnt_d   = '0;
            state_d = ST_HOLD;
          end
        end
        ST_HOLD: begin
          if (btn_m != btn_q) begin
            cnt_d   = '0;
            state_d = ST_ARMED;
          end else if (cnt_q == CNT_W'(REPEAT_DELAY - 1)) begin
            step    = 1'b1;
            cnt_d   = '0;
            state_d = ST_REPEAT;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        ST_REPEAT: begin
          if (btn_m != btn_q) begin
            cnt_d   = '0;
            state_d = ST_ARMED;
          end else if (cnt_q == CNT_W'(REPEAT_PERIOD - 1)) begin
            step  = 1'b1;
            cnt_d = '0;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // Out-of-range fields on the running bus load as zero.
  always_comb begin
    tin     = unpack_time(time_in);
    hh_load = (int'(tin.hh) >= HOUR_MOD) ? '0 : tin.hh;
    mm_load = (tin.mm >= 6'd60) ? '0 : tin.mm;
    ss_load = (SEC_EN == 0 || tin.ss >= 6'd60) ? '0 : tin.ss;
  end

  mod_step #(.WIDTH(HH_W), .MOD(HOUR_MOD)) u_hh_step (
    .val  (hh_q),
    .up   (step & btn_m[5]),
    .dn   (step & btn_m[4]),
    .next (hh_step)
  );

  mod_step #(.WIDTH(MM_W), .MOD(60)) u_mm_step (
    .val  (mm_q),
    .up   (step & btn_m[3]),
    .dn   (step & btn_m[2]),
    .next (mm_step)
  );

  mod_step #(.WIDTH(SS_W), .MOD(60)) u_ss_step (
    .val  (ss_q),
    .up   (step & btn_m[1]),
    .dn   (step & btn_m[0]),
    .next (ss_step)
  );

  always_comb begin
    hh_d = load ? hh_load : hh_step;
    mm_d = load ? mm_load : mm_step;
    ss_d = (SEC_EN == 0) ? '0 : (load ? ss_load : ss_step);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= ST_IDLE;
      set_en_q <= 1'b0;
      btn_q    <= '0;
      cnt_q    <= '0;
      done_q   <= 1'b0;
      hh_q     <= '0;
      mm_q     <= '0;
      ss_q     <= '0;
    end else begin
      state_q  <= state_d;
      set_en_q <= set_en;
      btn_q    <= btn_d;
      cnt_q    <= cnt_d;
      done_q   <= done_d;
      hh_q     <= hh_d;
      mm_q     <= mm_d;
      ss_q     <= ss_d;
    end
  end

  always_comb begin
    tcur.hh = hh_q;
    tcur.mm = mm_q;
    tcur.ss = ss_q;
  end

  assign time_out = pack_time(tcur);
  assign set_done = done_q;
  assign editing  = (state_q != ST_IDLE);

endmodule

// File: tb/tb_time_set_ctrl.sv
// tb/tb_time_set_ctrl.sv - directed self-checking bench for time_set_ctrl
module tb_time_set_ctrl;

  logic        clk;
  logic        rst;
  logic        set_en;
  logic [5:0]  button;
  logic [23:0] time_in;
  logic [23:0] tout_a, tout_b;
  logic        done_a, done_b;
  logic        edit_a, edit_b;

  int compared   = 0;
  int mismatched = 0;
  int hold_exp[10] = '{22, 22, 22, 22, 23, 23, 0, 0, 1, 1};

  time_set_ctrl #(
    .HOUR_MOD(24), .REPEAT_DELAY(4), .REPEAT_PERIOD(2), .SEC_EN(1)
  ) dut (
    .clk(clk), .rst(rst), .set_en(set_en), .button(button), .time_in(time_in),
    .time_out(tout_a), .set_done(done_a), .editing(edit_a)
  );

  time_set_ctrl #(
    .HOUR_MOD(24), .REPEAT_DELAY(4), .REPEAT_PERIOD(2), .SEC_EN(0)
  ) dut_nosec (
    .clk(clk), .rst(rst), .set_en(set_en), .button(button), .time_in(time_in),
    .time_out(tout_b), .set_done(done_b), .editing(edit_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp)
    else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    rst     = 1'b0;
    set_en  = 1'b0;
    button  = 6'b0;
    time_in = 24'h0;
    #12;
    check("reset_time_out", 32'(tout_a), 32'h0);
    check("reset_set_done", 32'(done_a), 32'h0);
    check("reset_editing", 32'(edit_a), 32'h0);
    @(negedge clk);
    rst = 1'b1;
    tick(1);

    // Entry loads 12:34:56
    time_in = 24'h0C2238;
    set_en  = 1'b1;
    tick(1);
    check("load_editing", 32'(edit_a), 32'h1);
    tick(1);
    check("load_time", 32'(tout_a), 32'h0C2238);
    check("load_time_nosec", 32'(tout_b), 32'h0C2200);
    check("load_editing_nosec", 32'(edit_b), 32'h1);

    // Exit, then re-enter with 21:00:59
    set_en = 1'b0;
    tick(1);
    check("exit_set_done", 32'(done_a), 32'h1);
    check("exit_editing", 32'(edit_a), 32'h0);
    check("exit_time_held", 32'(tout_a), 32'h0C2238);
    time_in = 24'h15003B;
    set_en  = 1'b1;
    tick(1);
    check("done_one_cycle", 32'(done_a), 32'h0);
    tick(1);
    check("reload_time", 32'(tout_a), 32'h15003B);

    // Hold hour+ for 10 cycles: steps at cycles 0, 4, 6, 8
    button = 6'b100000;
    for (int k = 0; k < 10; k++) begin
      tick(1);
      check($sformatf("hold_hh_%0d", k), 32'(tout_a[20:16]), 32'(hold_exp[k]));
    end
    button = 6'b0;
    tick(1);
    check("release_no_step", 32'(tout_a), 32'h01003B);

    // min- wraps 0 -> 59, sec+ wraps 59 -> 0 without touching minutes
    button = 6'b000100;
    tick(1);
    button = 6'b0;
    tick(1);
    check("min_dec_wrap", 32'(tout_a), 32'h013B3B);
    button = 6'b000010;
    tick(1);
    button = 6'b0;
    tick(1);
    check("sec_inc_wrap", 32'(tout_a), 32'h013B00);

    // Two buttons at once never step
    button = 6'b101000;
    tick(10);
    check("multi_press", 32'(tout_a), 32'h013B00);
    button = 6'b0;
    tick(1);

    // Single-cycle hour- gives exactly one decrement
    button = 6'b010000;
    tick(1);
    button = 6'b0;
    tick(6);
    check("hour_dec_once", 32'(tout_a), 32'h003B00);

    // Reload 30:10:45: hour out of range, seconds dropped without SEC_EN
    set_en = 1'b0;
    tick(1);
    time_in = 24'h1E0A2D;
    set_en  = 1'b1;
    tick(2);
    check("hh_range_load", 32'(tout_a), 32'h000A2D);
    check("nosec_load", 32'(tout_b), 32'h000A00);
    button = 6'b000010;
    tick(1);
    button = 6'b0;
    tick(1);
    check("sec_inc", 32'(tout_a), 32'h000A2E);
    check("nosec_sec_ignored", 32'(tout_b), 32'h000A00);

    // Exit while holding min+, on the cycle the repeat step would fire
    button = 6'b001000;
    tick(4);
    check("hold_min_first", 32'(tout_a), 32'h000B2E);
    check("hold_min_no_done", 32'(done_a), 32'h0);
    set_en = 1'b0;
    tick(1);
    check("exit_hold_done", 32'(done_a), 32'h1);
    check("exit_hold_done_nosec", 32'(done_b), 32'h1);
    check("exit_hold_editing", 32'(edit_a), 32'h0);
    check("exit_hold_mm", 32'(tout_a), 32'h000B2E);
    tick(1);
    check("exit_hold_done_clear", 32'(done_a), 32'h0);
    check("idle_ignores_button", 32'(tout_a), 32'h000B2E);
    button = 6'b0;

    // Reset while auto-repeating
    set_en = 1'b1;
    tick(2);
    check("reenter_load", 32'(tout_a), 32'h000A2D);
    button = 6'b100000;
    tick(6);
    check("repeat_before_rst", 32'(tout_a), 32'h020A2D);
    rst = 1'b0;
    #2;
    check("rst_time_out", 32'(tout_a), 32'h0);
    check("rst_editing", 32'(edit_a), 32'h0);
    check("rst_set_done", 32'(done_a), 32'h0);
    tick(2);
    check("rst_set_done_hold", 32'(done_a), 32'h0);
    button = 6'b0;
    set_en = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/time_set_ctrl.md
Name: time_set_ctrl

Overview:
- Parametrised time-setting controller. Successor to the hour/minute setter.
- Adds a seconds field, edge-triggered stepping, hold-to-auto-repeat and load-from-running-time on entry to set mode.
- Sits between the push-button/switch inputs and the timekeeping counter. Drives the packed time bus that the counter loads from and the display reads.

Parameters:
- HOUR_MOD, 24, hour field modulus; legal range 2..32.
- REPEAT_DELAY, 50_000_000, cycles a single button is held before auto-repeat starts; must be ≥2.
- REPEAT_PERIOD, 10_000_000, cycles between auto-repeat steps; must be ≥1.
- SEC_EN, 1, 1 = seconds buttons active; 0 = seconds field forced to 0 and sec buttons ignored.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous active-low reset.
- set_en  in  1  set-mode switch, level.
- button  in  6  bits [5:0] = hour+, hour-, min+, min-, sec+, sec-; active-high, already synchronised.
- time_in  in  24  running time, packed {3'b0, hh[4:0], 2'b0, mm[5:0], 2'b0, ss[5:0]}.
- time_out  out  24  edited time, same packing.
- set_done  out  1  one-cycle pulse on set-mode exit.
- editing  out  1  high while in set mode.

Behaviour:
- Reset (rst low, async): hh/mm/ss = 0, time_out = 0, set_done = 0, editing = 0, FSM = IDLE, repeat counter = 0.
- Packing: the pad bits of time_out are always 0. Fields are registered; time_out is a direct concatenation, so a field update appears on time_out one cycle after the cycle that decides the step.
- Field arithmetic:
  - hour+ : hh = (hh == HOUR_MOD-1) ? 0 : hh+1; hour- : hh = (hh == 0) ? HOUR_MOD-1 : hh-1.
  - Minutes and seconds step the same way, modulus 60.
  - No carry between fields.
- Load: on a set_en 0→1 edge (set_en registered one cycle for edge detect), copy time_in fields into hh/mm/ss. Any out-of-range field (hh ≥ HOUR_MOD, mm/ss ≥ 60) loads as 0. With SEC_EN=0, ss loads 0.
- FSM states:
  - IDLE: set_en low; buttons ignored; fields hold. Rising set_en → LOAD.
  - LOAD: one cycle; perform load. → ARMED.
  - ARMED: waiting for a valid press. A valid press is exactly one bit of button high, excluding sec bits when SEC_EN=0. On a valid press: apply one step that cycle, clear counter → HOLD.
  - HOLD: same single button still held; counter increments. At counter == REPEAT_DELAY-1: step, clear counter → REPEAT.
  - REPEAT: counter increments. At counter == REPEAT_PERIOD-1: step, clear counter.
- Leaving HOLD/REPEAT:
  - If button changes to zero or any other pattern (including multi-bit), return to ARMED with no step that cycle.
  - A new valid single button is then accepted from ARMED on the following cycle.
- Simultaneous presses: multi-bit patterns are never valid; no step, no repeat.
- Exit: set_en low in any non-IDLE state → IDLE. set_done = 1 for exactly that one cycle; fields hold their values and are not stepped that cycle.
- editing = 1 in LOAD/ARMED/HOLD/REPEAT; 0 in IDLE.
- Reset mid-edit: immediate return to reset values; no set_done.
- Counter width: clog2(max(REPEAT_DELAY, REPEAT_PERIOD)).

Decomposition:
- Shared package time_pkg:
  - field width constants HH_W=5, MM_W=6, SS_W=6;
  - TIME_BUS_W=24;
  - bus pack/unpack functions;
  - FSM state enum.
- Sub-module mod_step: combinational modulo inc/dec, parameters WIDTH and MOD, ports val, up, dn → next. Instantiated three times.

Test Plan:
- Reset, then set_en=1 with time_in=12:34:56 → after LOAD, time_out = {3'b0, 5'd12, 2'b0, 6'd34, 2'b0, 6'd56}; editing=1.
- Bench overrides REPEAT_DELAY=4, REPEAT_PERIOD=2. Hold hour+ from hh=21 for 10 cycles → steps at cycles 0, 4, 6, 8 → hh = 22, 23, 0, 1; no further step.
- mm=0, pulse min- one cycle → mm=59. ss=59, pulse sec+ → ss=0. mm is unchanged by the seconds wrap.
- button=6'b101000 held 10 cycles → no field change.
- Release to 0, then hour- single cycle → exactly one decrement.
- SEC_EN=0, time_in ss=45, sec+ pressed → ss stays 0.
- Load with time_in hh=30 (HOUR_MOD=24) → hh=0.
- set_en 1→0 while holding min+ → set_done high exactly one cycle, mm unchanged that cycle, editing=0.
- Assert rst mid-REPEAT → time_out=0 immediately, set_done stays 0.
